// File: rtl/bus_pkg.sv
// Shared types and constants for the OR-bus arbiter.
package bus_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    ACTIVE     = 2'd2,
    TURNAROUND = 2'd3
  } arb_state_t;

  // Dead cycles inserted after a grant is released so OR-bus drivers can let go
  localparam int TURNAROUND_CYCLES   = 1;
  localparam int DEFAULT_NUM_MASTERS = 4;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration and OR-bus status signals between the masters/bus and the arbiter.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = bus_pkg::DEFAULT_NUM_MASTERS,
  parameter int OWNER_W     = $clog2(NUM_MASTERS)
);

  logic [NUM_MASTERS-1:0] arb_request_i;
  logic [NUM_MASTERS-1:0] arb_grant_o;
  logic                   bus_beginTransaction_i;
  logic                   bus_endTransaction_i;
  logic                   bus_error_i;
  logic                   bus_busy_i;
  logic [OWNER_W-1:0]     bus_owner_o;
  logic                   bus_owned_o;
  logic                   arb_timeout_o;

  // Arbiter side
  modport slave (
    input  arb_request_i, bus_beginTransaction_i, bus_endTransaction_i,
           bus_error_i, bus_busy_i,
    output arb_grant_o, bus_owner_o, bus_owned_o, arb_timeout_o
  );

  // Requester / bus side
  modport master (
    output arb_request_i, bus_beginTransaction_i, bus_endTransaction_i,
           bus_error_i, bus_busy_i,
    input  arb_grant_o, bus_owner_o, bus_owned_o, arb_timeout_o
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_MASTERS = bus_pkg::DEFAULT_NUM_MASTERS,
  parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     ptr,
  output logic                   found,
  output logic [OWNER_W-1:0]     idx
);

  localparam logic [OWNER_W:0] N_W = (OWNER_W+1)'(NUM_MASTERS);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic [OWNER_W:0]         off;
  logic [OWNER_W:0]         sum;

  assign dbl   = {req, req};
  assign found = |req;

  // Rotate the doubled vector so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    rot = '0;
    off = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      rot[k] = dbl[int'(ptr) + k];
    end
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (rot[k]) off = (OWNER_W+1)'(k);
    end
    sum = {1'b0, ptr} + off;
    idx = (sum >= N_W) ? OWNER_W'(sum - N_W) : OWNER_W'(sum);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared OR-bus: grant, hold through the transaction,
// revoke unused grants, and insert a turnaround cycle before re-arbitrating.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter int OWNER_W        = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bif
);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic                   owned_q, owned_d;
  logic                   timeout_q, timeout_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  // Shared counter: grant-unused cycles in GRANTED, dead cycles in TURNAROUND
  logic [7:0]             cnt_q, cnt_d;

  logic                   pick_found;
  logic [OWNER_W-1:0]     pick_idx;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_W     (OWNER_W)
  ) u_pick (
    .req   (bif.arb_request_i),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    owned_d   = owned_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Busy bus blocks arbitration entirely; requests simply wait
        if (pick_found && !bif.bus_busy_i) begin
          grant_d = NUM_MASTERS'(1) << pick_idx;
          owner_d = pick_idx;
          owned_d = 1'b1;
          ptr_d   = (pick_idx == OWNER_W'(NUM_MASTERS-1)) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        // begin beats a simultaneous timeout
        if (bif.bus_beginTransaction_i) begin
          state_d = ACTIVE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES-1)) begin
          grant_d   = '0;
          owned_d   = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = TURNAROUND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACTIVE: begin
        // No timeout here; repeated begin strobes are ignored
        if (bif.bus_endTransaction_i || bif.bus_error_i) begin
          grant_d = '0;
          owned_d = 1'b0;
          cnt_d   = '0;
          state_d = TURNAROUND;
        end
      end
      TURNAROUND: begin
        if (cnt_q == 8'(TURNAROUND_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      owned_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      owned_q   <= owned_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bif.arb_grant_o   = grant_q;
  assign bif.bus_owner_o   = owner_q;
  assign bif.bus_owned_o   = owned_q;
  assign bif.arb_timeout_o = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;

  localparam int N       = 4;
  localparam int OW      = 2;
  localparam int TIMEOUT = 16;
  localparam int DEAD    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(N), .OWNER_W(OW)) bif ();

  bus_arbiter #(.NUM_MASTERS(N), .OWNER_W(OW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  // phase: 0 waiting to arbitrate, 1 grant unused, 2 transfer in progress, 3 dead time
  int m_phase, m_owner, m_ptr, m_unused, m_dead;
  bit m_owned, m_tmo;

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_unused = 0; m_dead = 0;
    m_owned = 0; m_tmo = 0;
  endtask

  task automatic m_step(input logic [N-1:0] req, input bit b, input bit e,
                        input bit er, input bit busy);
    bit hit;
    m_tmo = 0;
    case (m_phase)
      0: if (req != 0 && !busy) begin
           hit = 0;
           for (int i = 0; i < N; i++) begin
             if (!hit && req[(m_ptr + i) % N]) begin
               hit = 1; m_owner = (m_ptr + i) % N;
             end
           end
           m_ptr = (m_owner + 1) % N;
           m_owned = 1; m_unused = 0; m_phase = 1;
         end
      1: if (b) m_phase = 2;
         else begin
           m_unused++;
           if (m_unused == TIMEOUT) begin
             m_owned = 0; m_tmo = 1; m_dead = DEAD; m_phase = 3;
           end
         end
      2: if (e || er) begin m_owned = 0; m_dead = DEAD; m_phase = 3; end
      default: begin m_dead--; if (m_dead == 0) m_phase = 0; end
    endcase
  endtask

  // Advance the model on every edge and compare just after it
  always begin
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(bif.arb_request_i, bif.bus_beginTransaction_i,
                bif.bus_endTransaction_i, bif.bus_error_i, bif.bus_busy_i);
    #1;
    if (rst_n) begin
      chk("m_grant", 64'(bif.arb_grant_o), m_owned ? 64'(1) << m_owner : 64'd0);
      chk("m_owned", 64'(bif.bus_owned_o), 64'(m_owned));
      chk("m_timeout", 64'(bif.arb_timeout_o), 64'(m_tmo));
      if (m_owned) chk("m_owner", 64'(bif.bus_owner_o), 64'(m_owner));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    bif.arb_request_i          = '0;
    bif.bus_beginTransaction_i = 1'b0;
    bif.bus_endTransaction_i   = 1'b0;
    bif.bus_error_i            = 1'b0;
    bif.bus_busy_i             = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (at negedges) for any grant; returns number of grant-free cycles seen
  task automatic wait_grant(output int waited);
    waited = 0;
    while (bif.arb_grant_o == '0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bif.arb_grant_o == '0) chk("wait_grant_timeout", 64'd0, 64'd1);
  endtask

  int w, cnt, tmo;

  initial begin
    clr_in();
    #2;
    chk("rst_grant", 64'(bif.arb_grant_o), 64'd0);
    chk("rst_owned", 64'(bif.bus_owned_o), 64'd0);
    chk("rst_owner", 64'(bif.bus_owner_o), 64'd0);
    chk("rst_timeout", 64'(bif.arb_timeout_o), 64'd0);

    // T1: single master, begin at cycle 3, end at cycle 6
    do_reset();
    bif.arb_request_i = 4'b0001;
    @(negedge clk); chk("t1_grant_c1", 64'(bif.arb_grant_o), 64'b0001);
    bif.arb_request_i = '0;
    @(negedge clk);
    @(negedge clk); bif.bus_beginTransaction_i = 1'b1;
    @(negedge clk); bif.bus_beginTransaction_i = 1'b0;
    @(negedge clk);
    @(negedge clk); bif.bus_endTransaction_i = 1'b1;
    chk("t1_grant_c6", 64'(bif.arb_grant_o), 64'b0001);
    chk("t1_owner", 64'(bif.bus_owner_o), 64'd0);
    @(negedge clk); bif.bus_endTransaction_i = 1'b0;
    chk("t1_turn_grant", 64'(bif.arb_grant_o), 64'd0);
    chk("t1_turn_owned", 64'(bif.bus_owned_o), 64'd0);

    // T2: all masters requesting, strict rotation, 2 dead cycles between grants
    do_reset();
    bif.arb_request_i = 4'b1111;
    wait_grant(w);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) chk("t2_gap", 64'(w), 64'd2);
      chk("t2_order", 64'(bif.bus_owner_o), 64'(i % N));
      bif.bus_beginTransaction_i = 1'b1;
      @(negedge clk); bif.bus_beginTransaction_i = 1'b0;
      @(negedge clk);
      @(negedge clk); bif.bus_endTransaction_i = 1'b1;
      @(negedge clk); bif.bus_endTransaction_i = 1'b0;
      wait_grant(w);
    end
    bif.arb_request_i = '0;
    bif.bus_beginTransaction_i = 1'b1;
    @(negedge clk); bif.bus_beginTransaction_i = 1'b0; bif.bus_endTransaction_i = 1'b1;
    @(negedge clk); bif.bus_endTransaction_i = 1'b0;

    // T3: unused grant revoked after TIMEOUT cycles, one pulse, regranted
    do_reset();
    bif.arb_request_i = 4'b0100;
    wait_grant(w);
    cnt = 0;
    while (bif.arb_grant_o != '0 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("t3_held_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("t3_pulse", 64'(bif.arb_timeout_o), 64'd1);
    @(negedge clk);
    chk("t3_pulse_once", 64'(bif.arb_timeout_o), 64'd0);
    wait_grant(w);
    chk("t3_regrant", 64'(bif.bus_owner_o), 64'd2);
    bif.arb_request_i = '0;
    repeat (TIMEOUT + 4) @(negedge clk);

    // T4: error ends the transfer, pointer moves past master 1
    do_reset();
    bif.arb_request_i = 4'b0010;
    wait_grant(w);
    chk("t4_owner1", 64'(bif.bus_owner_o), 64'd1);
    bif.arb_request_i = '0;
    bif.bus_beginTransaction_i = 1'b1;
    @(negedge clk); bif.bus_beginTransaction_i = 1'b0;
    @(negedge clk); bif.bus_error_i = 1'b1;
    @(negedge clk); bif.bus_error_i = 1'b0;
    chk("t4_err_drop", 64'(bif.arb_grant_o), 64'd0);
    bif.arb_request_i = 4'b1001;
    wait_grant(w);
    chk("t4_owner3", 64'(bif.arb_grant_o), 64'b1000);
    bif.arb_request_i = '0;
    bif.bus_beginTransaction_i = 1'b1;
    @(negedge clk); bif.bus_beginTransaction_i = 1'b0; bif.bus_endTransaction_i = 1'b1;
    @(negedge clk); bif.bus_endTransaction_i = 1'b0;

    // T5: busy holds off arbitration
    do_reset();
    bif.bus_busy_i = 1'b1;
    bif.arb_request_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t5_busy_nogrant", 64'(bif.arb_grant_o), 64'd0);
    end
    bif.bus_busy_i = 1'b0;
    @(negedge clk); chk("t5_grant", 64'(bif.arb_grant_o), 64'b0010);
    bif.arb_request_i = '0;

    // T6: async reset mid-transfer
    do_reset();
    bif.arb_request_i = 4'b1000;
    wait_grant(w);
    chk("t6_grant3", 64'(bif.arb_grant_o), 64'b1000);
    bif.bus_beginTransaction_i = 1'b1;
    @(negedge clk); bif.bus_beginTransaction_i = 1'b0; bif.arb_request_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 64'(bif.arb_grant_o), 64'd0);
    chk("t6_async_owned", 64'(bif.bus_owned_o), 64'd0);
    @(negedge clk); bif.arb_request_i = 4'b1001;
    @(negedge clk); rst_n = 1'b1;
    wait_grant(w);
    chk("t6_ptr_reset", 64'(bif.bus_owner_o), 64'd0);

    // Random traffic, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bif.arb_request_i          = N'($urandom);
      bif.bus_beginTransaction_i = ($urandom_range(0, 3) == 0);
      bif.bus_endTransaction_i   = ($urandom_range(0, 4) == 0);
      bif.bus_error_i            = ($urandom_range(0, 15) == 0);
      bif.bus_busy_i             = ($urandom_range(0, 7) == 0);
      // Occasionally starve begin so timeouts get exercised
      if (i % 500 > 400) bif.bus_beginTransaction_i = 1'b0;
    end
    @(negedge clk); clr_in();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
